// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state type and datapath geometry for the MAC job controller
package mac_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int LANES  = 16;
  localparam int LANE_W = 8;
  localparam int SUM_W  = 20;
  localparam int DATA_W = 2 * LANES * LANE_W;
endpackage

// File: rtl/mac_dot16.sv
// mac_dot16: 16-lane byte dot product of one 256-bit beat through a balanced adder tree
module mac_dot16
  import mac_pkg::*;
(
  input  logic [DATA_W-1:0] in_data,
  output logic [SUM_W-1:0]  beat_sum
);
  localparam int P_W = 2 * LANE_W;
  logic [P_W-1:0] p  [LANES];
  logic [P_W:0]   s1 [LANES/2];
  logic [P_W+1:0] s2 [LANES/4];
  logic [P_W+2:0] s3 [LANES/8];
  genvar i;
  for (i = 0; i < LANES; i++) begin : g_p
    assign p[i] = P_W'(in_data[2*LANE_W*i +: LANE_W]) * P_W'(in_data[2*LANE_W*i+LANE_W +: LANE_W]);
  end
  for (i = 0; i < LANES/2; i++) begin : g_s1
    assign s1[i] = {1'b0, p[2*i]} + {1'b0, p[2*i+1]};
  end
  for (i = 0; i < LANES/4; i++) begin : g_s2
    assign s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
  end
  for (i = 0; i < LANES/8; i++) begin : g_s3
    assign s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
  end
  assign beat_sum = {1'b0, s3[0]} + {1'b0, s3[1]};
endmodule

// File: rtl/mac_job_ctrl.sv
// mac_job_ctrl: job-sequenced dot-product accumulator; MAC_STALL_CNT_EN adds a stall_cnt output
module mac_job_ctrl
  import mac_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy
`ifdef MAC_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  state_t           state;
  logic [LEN_W:0]   remaining;
  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] beat_sum;
  logic             accept;
  mac_dot16 u_dot (.in_data(in_data), .beat_sum(beat_sum));
  assign accept   = state == IDLE && cmd_valid && cmd_ready;
  // the accumulator doubles as the result register, so it persists until the next accept
  assign out_data = acc;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      acc       <= '0;
      cmd_ready <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= !accept;
          if (accept) begin
            state     <= RUN;
            remaining <= cmd_len == '0 ? {1'b1, LEN_W'(0)} : {1'b0, cmd_len};
            acc       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: if (in_valid) begin
          acc       <= acc + ACC_W'(beat_sum);
          remaining <= remaining - (LEN_W+1)'(1);
          if (remaining == (LEN_W+1)'(1)) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MAC_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset || accept)
      stall_cnt <= '0;
    else if (state == RUN && !in_valid && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/mac_job_ctrl.md
MAC_JOB_CTRL -- requirements
Module: mac_job_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8, job-length field width (cmd_len = 0 encodes 2^LEN_W beats).
REQ-002 SHALL have parameter ACC_W, default 28, accumulator and result width.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid  input  1, cmd_ready  output  1, cmd_len  input  LEN_W: job command handshake and beat count.
REQ-006 SHALL have ports in_valid  input  1, in_ready  output  1, in_data  input  256: operand beat, byte k = in_data[8k+7:8k].
REQ-007 SHALL have ports out_valid  output  1, out_ready  input  1, out_data  output  ACC_W: result handshake and dot-product sum.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE states.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, DONE.
REQ-010 IDLE: cmd_ready=1, in_ready=0, out_valid=0; cmd_valid&cmd_ready -> load remaining=cmd_len (0 -> 2^LEN_W), clear accumulator to 0, go RUN.
REQ-011 RUN: in_ready=1, cmd_ready=0; each in_valid&in_ready beat adds beat_sum to accumulator and decrements remaining.
REQ-012 beat_sum SHALL be the unsigned sum over lanes i=0..15 of byte(2i)*byte(2i+1), computed at full 20-bit width (no truncation).
REQ-013 Accepting the beat with remaining==1 SHALL move to DONE; out_valid SHALL be high on the next cycle with the final sum (1-cycle latency after last beat).
REQ-014 RUN with in_valid=0 SHALL hold accumulator and remaining unchanged (no timeout).
REQ-015 DONE: out_valid=1, out_data stable, in_ready=0, cmd_ready=0 until out_ready; out_valid&out_ready -> IDLE.
REQ-016 Accumulator SHALL be ACC_W bits, unsigned, wrap modulo 2^ACC_W; with defaults max sum 256*1040400 fits without wrap.
REQ-017 out_data SHALL retain the last result in IDLE; new jobs overwrite it only when accumulator clears.
REQ-018 Minimum job spacing SHALL be: last result handshake cycle followed by one IDLE cycle before next cmd accept.

Reset
REQ-019 reset=0 at any rising edge SHALL force IDLE, accumulator=0, remaining=0, out_data=0, out_valid=0, in_ready=0, busy=0, cmd_ready=0 during reset.
REQ-020 Reset mid-job SHALL abandon the job with no result emitted; cmd_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-021 Macro MAC_STALL_CNT_EN defined: SHALL add output stall_cnt (16 bits), cleared at cmd accept, incremented each RUN cycle with in_valid=0, saturating at 16'hFFFF, held through DONE/IDLE, reset to 0.
REQ-022 Macro MAC_STALL_CNT_EN undefined: stall_cnt port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-023 Shared package mac_pkg SHALL hold the FSM state enum, lane count (16), lane width (8), beat-sum width (20).
REQ-024 Combinational beat_sum SHALL be a sub-module mac_dot16 (256-bit in, 20-bit out, balanced adder tree); FSM, counter and accumulator stay in mac_job_ctrl.

Verification
REQ-025 cmd_len=1, in_data all bytes 8'h01 -> out_data=16 one cycle after the beat, busy drops after out_ready.
REQ-026 cmd_len=0, 256 beats all bytes 8'hFF -> out_data=266342400 (no wrap), exactly 256 beats accepted, in_ready=0 afterwards.
REQ-027 cmd_len=3, beats with byte0=2,byte1=3 (others 0), in_valid low 2 cycles between beats -> out_data=18; MAC_STALL_CNT_EN build: stall_cnt=4.
REQ-028 Result held with out_ready=0 for 5 cycles -> out_valid and out_data stable, cmd_valid high ignored (cmd_ready=0), in_ready=0.
REQ-029 reset=0 after 2 of 4 beats, then new cmd_len=1 with bytes 8'h02 -> only new result 64 appears, no stale value.
REQ-030 Two back-to-back jobs with cmd_valid held high -> second accepted exactly one cycle after first result handshake, accumulator starts from 0.
